// File: rtl/seq_detect_ctrl_if.sv
// Event handshake bundle for seq_detect_ctrl.
//   evt_valid : event available (producer -> consumer)
//   evt_ready : consumer ready (consumer -> producer)
//   evt_len   : length of the completed run, saturated (producer -> consumer)
// A transfer occurs on a clock edge where evt_valid & evt_ready.
// The master modport belongs to the controller; the slave modport belongs to the consumer.
interface seq_detect_ctrl_if #(
  parameter int unsigned CNT_W = 8
);
  logic             evt_valid;
  logic             evt_ready;
  logic [CNT_W-1:0] evt_len;

  modport master (output evt_valid, output evt_len, input evt_ready);
  modport slave  (input evt_valid, input evt_len, output evt_ready);
endinterface

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: armable run-length detection controller for serial bit streams.
// It detects N consecutive '1's, where N is programmable, and reports each completed
// run length on the event interface. It supports one-shot and continuous modes and
// tracks overflow.
//
// Optional feature: define SEQ_CTRL_TIMEOUT_EN to abandon ARMED after TIMEOUT_CYC
// cycles without a hit. Without the macro, timeout_o is tied to 0.
//
// Ports:
//   clk_i      in   clock, rising edge
//   rstn_i     in   asynchronous active-low reset
//   seq_i      in   serial bit, sampled on every rising edge
//   cfg_len_i  in   run length N, latched on arm; 0 is treated as 1
//   mode_i     in   0 = one-shot, 1 = continuous; latched on arm
//   arm_i      in   start pulse, honoured in IDLE only
//   disarm_i   in   abort pulse, honoured in any state; wins over arm_i
//   det_o      out  high while the current run length is >= N (registered)
//   busy_o     out  high in any state other than IDLE
//   evt        if   event handshake (valid / ready / len), master side
//   ovf_o      out  sticky flag, set when an event was dropped; cleared on arm
//   timeout_o  out  one-cycle pulse on the last ARMED cycle before a timeout
module seq_detect_ctrl #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               seq_i,
  input  logic [CNT_W-1:0]   cfg_len_i,
  input  logic               mode_i,
  input  logic               arm_i,
  input  logic               disarm_i,
  output logic               det_o,
  output logic               busy_o,
  seq_detect_ctrl_if.master  evt,
  output logic               ovf_o,
  output logic               timeout_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_HIT   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] run_cnt_q, run_inc;
  logic [CNT_W-1:0] len_q;
  logic             mode_q;
  logic             evt_valid_q;
  logic [CNT_W-1:0] evt_len_q;
  logic             ovf_q;
  logic             go_hit, post_evt, evt_hs, arm_ok, tmo_fire;

  // Saturating increment of the run counter.
  assign run_inc  = (run_cnt_q == '1) ? run_cnt_q : run_cnt_q + CNT_W'(1);
  assign go_hit   = (state_q == S_ARMED) && seq_i && (run_inc >= len_q);
  // A run that ends in the same cycle as a disarm is discarded, not reported.
  assign post_evt = (state_q == S_HIT) && !seq_i && !disarm_i;
  assign evt_hs   = evt_valid_q && evt.evt_ready;
  assign arm_ok   = (state_q == S_IDLE) && arm_i && !disarm_i;

`ifdef SEQ_CTRL_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [TMO_W-1:0] tmo_cnt_q;

  // The counter holds the number of ARMED cycles already completed. It returns to 0
  // whenever the controller leaves ARMED, so every entry into ARMED starts from 0.
  // This includes the return from HIT after an event is posted.
  assign tmo_fire = (state_q == S_ARMED) && !go_hit && !disarm_i && (tmo_cnt_q == TMO_LAST);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tmo_cnt_q <= '0;
    end else if ((state_q == S_ARMED) && (state_d == S_ARMED)) begin
      tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
    end else begin
      tmo_cnt_q <= '0;
    end
  end
`else
  assign tmo_fire = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (disarm_i) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (arm_i) state_d = S_ARMED;
        S_ARMED: begin
          if (go_hit)        state_d = S_HIT;
          else if (tmo_fire) state_d = S_IDLE;
        end
        S_HIT:   if (!seq_i) state_d = mode_q ? S_ARMED : S_DONE;
        S_DONE:  if (!evt_valid_q || evt_hs) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output logic.
  always_comb begin
    det_o     = (state_q == S_HIT);
    busy_o    = (state_q != S_IDLE);
    timeout_o = tmo_fire;
  end

  // Datapath: run counter, latched configuration, event slot, and overflow flag.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      run_cnt_q   <= '0;
      len_q       <= '0;
      mode_q      <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_len_q   <= '0;
      ovf_q       <= 1'b0;
    end else begin
      if (disarm_i) begin
        run_cnt_q <= '0;
      end else begin
        unique case (state_q)
          S_ARMED: run_cnt_q <= (seq_i && !tmo_fire) ? run_inc : '0;
          S_HIT:   run_cnt_q <= seq_i ? run_inc : '0;
          default: run_cnt_q <= '0;
        endcase
      end

      if (arm_ok) begin
        len_q  <= (cfg_len_i == '0) ? CNT_W'(1) : cfg_len_i;
        mode_q <= mode_i;
        ovf_q  <= 1'b0;
      end

      // The slot can take a new event when it is empty or when it is being drained
      // on this same edge. Otherwise the new event is dropped and the pending one is kept.
      if (post_evt) begin
        if (!evt_valid_q || evt_hs) begin
          evt_valid_q <= 1'b1;
          evt_len_q   <= run_cnt_q;
        end else begin
          ovf_q <= 1'b1;
        end
      end else if (evt_hs) begin
        evt_valid_q <= 1'b0;
      end
    end
  end

  assign evt.evt_valid = evt_valid_q;
  assign evt.evt_len   = evt_len_q;
  assign ovf_o         = ovf_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl.
// The main instance uses CNT_W=8 and TIMEOUT_CYC=10. A second instance with CNT_W=4
// covers counter saturation. Expected event lengths are queued as each run is driven.
// They are popped and compared whenever the main instance completes a handshake.
module tb_seq_detect_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       seq, mode, arm, disarm;
  logic [7:0] cfg_len;
  logic       det, busy, ovf, tmo;

  logic       arm4;
  logic [3:0] cfg4;
  logic       det4, busy4, ovf4, tmo4;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned exp_q[$];

  seq_detect_ctrl_if #(.CNT_W(8)) ev  ();
  seq_detect_ctrl_if #(.CNT_W(4)) ev4 ();

  seq_detect_ctrl #(.CNT_W(8), .TIMEOUT_CYC(10)) u_dut (
    .clk_i(clk), .rstn_i(rstn), .seq_i(seq), .cfg_len_i(cfg_len), .mode_i(mode),
    .arm_i(arm), .disarm_i(disarm), .det_o(det), .busy_o(busy), .evt(ev),
    .ovf_o(ovf), .timeout_o(tmo)
  );

  seq_detect_ctrl #(.CNT_W(4), .TIMEOUT_CYC(10)) u_dut4 (
    .clk_i(clk), .rstn_i(rstn), .seq_i(seq), .cfg_len_i(cfg4), .mode_i(mode),
    .arm_i(arm4), .disarm_i(disarm), .det_o(det4), .busy_o(busy4), .evt(ev4),
    .ovf_o(ovf4), .timeout_o(tmo4)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s);
    seq = s;
    tick();
  endtask

  task automatic arm_with(input logic [7:0] len, input logic m);
    cfg_len = len;
    mode    = m;
    arm     = 1'b1;
    tick();
    arm     = 1'b0;
  endtask

  task automatic do_disarm();
    disarm = 1'b1;
    tick();
    disarm = 1'b0;
  endtask

  // Scoreboard: every handshake on the main instance must match the oldest expected length.
  always @(negedge clk) begin
    if (rstn && ev.evt_valid && ev.evt_ready) begin
      check_eq("evt_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check_eq("evt_len", ev.evt_len, exp_q.pop_front());
    end
  end

  initial begin
    #100us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; seq = 1'b0; mode = 1'b0; arm = 1'b0; disarm = 1'b0; cfg_len = '0;
    arm4 = 1'b0; cfg4 = '0;
    ev.evt_ready = 1'b0; ev4.evt_ready = 1'b0;
    repeat (3) tick();
    check_eq("rst_det",   det, 0);
    check_eq("rst_busy",  busy, 0);
    check_eq("rst_valid", ev.evt_valid, 0);
    check_eq("rst_len",   ev.evt_len, 0);
    check_eq("rst_ovf",   ovf, 0);
    check_eq("rst_tmo",   tmo, 0);
    rstn = 1'b1;
    tick();

    // 1: len 5, one-shot
    arm_with(8'd5, 1'b0);
    check_eq("t1_busy", busy, 1);
    for (int i = 0; i < 4; i++) drive(1'b1);
    check_eq("t1_det_4th", det, 0);
    drive(1'b1);
    check_eq("t1_det_5th", det, 1);
    exp_q.push_back(5);
    drive(1'b0);
    check_eq("t1_det_low", det, 0);
    check_eq("t1_valid", ev.evt_valid, 1);
    tick();
    check_eq("t1_wait_done", busy, 1);
    ev.evt_ready = 1'b1;
    tick();
    ev.evt_ready = 1'b0;
    check_eq("t1_idle", busy, 0);
    check_eq("t1_valid_clr", ev.evt_valid, 0);

    // 2: len 3, continuous, consumer stalled -> overflow
    arm_with(8'd3, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1);
    exp_q.push_back(4);
    drive(1'b0);
    check_eq("t2_valid", ev.evt_valid, 1);
    check_eq("t2_busy_cont", busy, 1);
    for (int i = 0; i < 6; i++) drive(1'b1);
    drive(1'b0);
    check_eq("t2_ovf", ovf, 1);
    check_eq("t2_held_len", ev.evt_len, 4);
    do_disarm();
    check_eq("t2_disarm_idle", busy, 0);
    check_eq("t2_pending_kept", ev.evt_valid, 1);
    ev.evt_ready = 1'b1;
    tick();
    ev.evt_ready = 1'b0;
    check_eq("t2_ovf_sticky", ovf, 1);
    arm_with(8'd0, 1'b0);           // len 0 behaves as 1
    check_eq("t2_ovf_clr", ovf, 0);
    drive(1'b1);
    check_eq("len1_det", det, 1);
    exp_q.push_back(1);
    drive(1'b0);
    ev.evt_ready = 1'b1;
    tick();
    check_eq("len1_idle", busy, 0);

    // 3: len 3, continuous, consumer ready
    arm_with(8'd3, 1'b1);
    drive(1'b1); drive(1'b1);
    check_eq("t3_no_det", det, 0);
    drive(1'b0);
    drive(1'b1); drive(1'b1);
    check_eq("t3_det_2", det, 0);
    drive(1'b1);
    check_eq("t3_det_3", det, 1);
    exp_q.push_back(3);
    drive(1'b0);
    check_eq("t3_valid", ev.evt_valid, 1);
    drive(1'b0);
    check_eq("t3_drained", ev.evt_valid, 0);
    do_disarm();

    // 3b: new event on the same edge as a handshake
    ev.evt_ready = 1'b0;
    arm_with(8'd2, 1'b1);
    drive(1'b1); drive(1'b1);
    exp_q.push_back(2);
    drive(1'b0);
    drive(1'b1); drive(1'b1); drive(1'b1);
    ev.evt_ready = 1'b1;
    exp_q.push_back(3);
    drive(1'b0);
    check_eq("hs_post_valid", ev.evt_valid, 1);
    check_eq("hs_post_len", ev.evt_len, 3);
    check_eq("hs_post_ovf", ovf, 0);
    drive(1'b0);
    check_eq("hs_post_drain", ev.evt_valid, 0);
    do_disarm();

    // 4: CNT_W=4 saturation (main instance idle)
    cfg4 = 4'd2; mode = 1'b0; arm4 = 1'b1;
    tick();
    arm4 = 1'b0;
    for (int i = 0; i < 20; i++) drive(1'b1);
    check_eq("t4_det", det4, 1);
    check_eq("t4_main_idle", busy, 0);
    drive(1'b0);
    check_eq("t4_valid", ev4.evt_valid, 1);
    check_eq("t4_sat_len", ev4.evt_len, 15);
    ev4.evt_ready = 1'b1;
    tick();
    check_eq("t4_idle", busy4, 0);

    // 5: disarm during HIT with simultaneous arm and run end
    arm_with(8'd2, 1'b0);
    drive(1'b1); drive(1'b1); drive(1'b1);
    check_eq("t5_hit", det, 1);
    disarm = 1'b1; arm = 1'b1; seq = 1'b0;
    tick();
    disarm = 1'b0; arm = 1'b0;
    check_eq("t5_busy", busy, 0);
    check_eq("t5_det", det, 0);
    check_eq("t5_no_evt", ev.evt_valid, 0);
    tick();
    check_eq("t5_stay_idle", busy, 0);

    // 6: timeout (or its absence)
    arm_with(8'd4, 1'b0);
`ifdef SEQ_CTRL_TIMEOUT_EN
    for (int i = 1; i < 10; i++) begin
      check_eq("t6_no_tmo_yet", tmo, 0);
      drive(1'b0);
    end
    check_eq("t6_tmo_pulse", tmo, 1);
    drive(1'b0);
    check_eq("t6_tmo_idle", busy, 0);
    check_eq("t6_tmo_end", tmo, 0);
`else
    for (int i = 0; i < 30; i++) begin
      drive(1'b0);
      check_eq("t6_tmo_tied", tmo, 0);
    end
    check_eq("t6_still_armed", busy, 1);
    do_disarm();
`endif

    // asynchronous reset mid-run
    arm_with(8'd2, 1'b0);
    drive(1'b1); drive(1'b1);
    check_eq("ar_hit", det, 1);
    rstn = 1'b0;
    #1;
    check_eq("ar_det", det, 0);
    check_eq("ar_busy", busy, 0);
    tick();
    rstn = 1'b1;
    seq = 1'b0;
    tick();

    check_eq("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
